// File: rtl/line_buffer_5x5.sv
// Four-line raster buffer feeding a 5x5 window stage: each accepted pixel
// emits the column of five vertically adjacent pixels ending at that pixel.
module line_buffer_5x5 #(
  parameter int COLS = 5,
  parameter int ROWS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_valid_i,
  input  logic [7:0] data_i,
  output logic [7:0] S1_o,
  output logic [7:0] S2_o,
  output logic [7:0] S3_o,
  output logic [7:0] S4_o,
  output logic [7:0] S5_o,
  output logic       valid_o,
  output logic       frame_done_o
);

  localparam int         AW      = $clog2(COLS);
  localparam logic [9:0] LastCol = 10'(COLS - 1);
  localparam logic [9:0] LastRow = 10'(ROWS - 1);

  logic [7:0] l0_q [0:COLS-1];
  logic [7:0] l1_q [0:COLS-1];
  logic [7:0] l2_q [0:COLS-1];
  logic [7:0] l3_q [0:COLS-1];

  logic [9:0]    col_q, col_d;
  logic [9:0]    row_q, row_d;
  logic [AW-1:0] colIdx;
  logic [7:0]    rd0, rd1, rd2, rd3;
  logic          lastPix;

  logic [7:0] s1_q, s2_q, s3_q, s4_q, s5_q;
  logic       valid_q, frameDone_q;

  assign colIdx  = col_q[AW-1:0];
  assign rd0     = l0_q[colIdx];
  assign rd1     = l1_q[colIdx];
  assign rd2     = l2_q[colIdx];
  assign rd3     = l3_q[colIdx];
  assign lastPix = (col_q == LastCol) && (row_q == LastRow);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (data_valid_i) begin
      if (col_q == LastCol) begin
        col_d = 10'd0;
        row_d = (row_q == LastRow) ? 10'd0 : row_q + 10'd1;
      end else begin
        col_d = col_q + 10'd1;
      end
    end
  end

  // Line memories carry no reset; rows 0..3 of every frame overwrite them
  // before valid_o can rise, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (data_valid_i && !rst) begin
      l0_q[colIdx] <= data_i;
      l1_q[colIdx] <= rd0;
      l2_q[colIdx] <= rd1;
      l3_q[colIdx] <= rd2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 8'd0;
      s2_q        <= 8'd0;
      s3_q        <= 8'd0;
      s4_q        <= 8'd0;
      s5_q        <= 8'd0;
      valid_q     <= 1'b0;
      frameDone_q <= 1'b0;
      col_q       <= 10'd0;
      row_q       <= 10'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (data_valid_i) begin
        s5_q        <= data_i;
        s4_q        <= rd0;
        s3_q        <= rd1;
        s2_q        <= rd2;
        s1_q        <= rd3;
        valid_q     <= (row_q >= 10'd4);
        frameDone_q <= lastPix;
      end else begin
        valid_q     <= 1'b0;
        frameDone_q <= 1'b0;
      end
    end
  end

  assign S1_o         = s1_q;
  assign S2_o         = s2_q;
  assign S3_o         = s3_q;
  assign S4_o         = s4_q;
  assign S5_o         = s5_q;
  assign valid_o      = valid_q;
  assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_line_buffer_5x5.sv
// Directed bench for line_buffer_5x5: a 5x5 instance and a 7-column x 6-row
// instance, each pixel's column checked against a pixel-index formula.
module tb_line_buffer_5x5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       dv5, av, ad;
  logic [7:0] d5, a1, a2, a3, a4, a5;
  logic       dv7, bv, bd;
  logic [7:0] d7, b1, b2, b3, b4, b5;

  line_buffer_5x5 #(.COLS(5), .ROWS(5)) dut5 (
    .clk(clk), .rst(rst), .data_valid_i(dv5), .data_i(d5),
    .S1_o(a1), .S2_o(a2), .S3_o(a3), .S4_o(a4), .S5_o(a5),
    .valid_o(av), .frame_done_o(ad)
  );

  line_buffer_5x5 #(.COLS(7), .ROWS(6)) dut7 (
    .clk(clk), .rst(rst), .data_valid_i(dv7), .data_i(d7),
    .S1_o(b1), .S2_o(b2), .S3_o(b3), .S4_o(b4), .S5_o(b5),
    .valid_o(bv), .frame_done_o(bd)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] oS [1:5];
  logic       oValid, oDone;
  int         nValid, nDone;

  function automatic logic [7:0] pix(input logic [7:0] base, input int r, input int c);
    return base + 8'(16 * r + c);
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sampleOut(input bit sel7);
    if (sel7) begin
      oS[1] = b1; oS[2] = b2; oS[3] = b3; oS[4] = b4; oS[5] = b5;
      oValid = bv; oDone = bd;
    end else begin
      oS[1] = a1; oS[2] = a2; oS[3] = a3; oS[4] = a4; oS[5] = a5;
      oValid = av; oDone = ad;
    end
  endtask

  // Drive one cycle on the falling edge, sample 1 time unit after the rising edge.
  task automatic applyStimulus(input bit sel7, input bit vld, input logic [7:0] v);
    @(negedge clk);
    if (sel7) begin
      dv7 = vld; d7 = v;
    end else begin
      dv5 = vld; d5 = v;
    end
    @(posedge clk);
    #1;
    sampleOut(sel7);
  endtask

  task automatic checkOutput(input string tag, input bit sel7);
    sampleOut(sel7);
    for (int k = 1; k <= 5; k++) checkVal($sformatf("%s S%0d", tag, k), oS[k], 0);
    checkVal({tag, " valid"}, oValid, 0);
    checkVal({tag, " done"}, oDone, 0);
  endtask

  task automatic runFrame(input bit sel7, input logic [7:0] base, input int rows,
                          input int cols, input bit gaps);
    logic [7:0] prev;
    bit havePrev;
    havePrev = 1'b0;
    prev     = 8'h00;
    nValid   = 0;
    nDone    = 0;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        if (gaps) begin
          int g;
          g = $urandom_range(0, 2);
          repeat (g) begin
            applyStimulus(sel7, 1'b0, 8'hA5);
            checkVal("gap valid", oValid, 0);
            checkVal("gap done", oDone, 0);
            if (havePrev) checkVal("gap hold S5", oS[5], prev);
          end
        end
        applyStimulus(sel7, 1'b1, pix(base, r, c));
        nValid += int'(oValid);
        nDone  += int'(oDone);
        checkVal($sformatf("valid r%0d c%0d", r, c), oValid, (r >= 4));
        checkVal($sformatf("done r%0d c%0d", r, c), oDone,
                 (r == rows - 1) && (c == cols - 1));
        if (r >= 4)
          for (int k = 1; k <= 5; k++)
            checkVal($sformatf("S%0d r%0d c%0d", k, r, c), oS[k], pix(base, r - 5 + k, c));
        prev     = pix(base, r, c);
        havePrev = 1'b1;
      end
    end
    applyStimulus(sel7, 1'b0, 8'h00);
    checkVal("done drops", oDone, 0);
    checkVal("valid drops", oValid, 0);
  endtask

  initial begin
    rst = 1'b1;
    dv5 = 1'b0; d5 = 8'h00;
    dv7 = 1'b0; d7 = 8'h00;
    #12;
    checkOutput("reset5", 1'b0);
    checkOutput("reset7", 1'b1);
    #5 rst = 1'b0;

    // Gap-free 5x5 frame: values 16*r+c, frame_done with S5=0x44.
    runFrame(1'b0, 8'h00, 5, 5, 1'b0);
    checkVal("frameA valid count", nValid, 5);
    checkVal("frameA done count", nDone, 1);

    // Same frame with random idle cycles between pixels.
    runFrame(1'b0, 8'h00, 5, 5, 1'b1);
    checkVal("frameGap valid count", nValid, 5);
    checkVal("frameGap done count", nDone, 1);

    // Two frames back to back; second frame's first four rows must stay invalid.
    runFrame(1'b0, 8'h00, 5, 5, 1'b0);
    runFrame(1'b0, 8'h80, 5, 5, 1'b0);
    checkVal("frame2 valid count", nValid, 5);
    checkVal("frame2 done count", nDone, 1);

    // Partial frame, then reset asserted and released between clock edges.
    for (int i = 0; i < 13; i++) applyStimulus(1'b0, 1'b1, 8'h40 + 8'(i));
    #2;
    rst = 1'b1;
    dv5 = 1'b0;
    #1;
    checkOutput("midReset async", 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midReset held", 1'b0);
    #3 rst = 1'b0;
    runFrame(1'b0, 8'h20, 5, 5, 1'b0);
    checkVal("postReset valid count", nValid, 5);
    checkVal("postReset done count", nDone, 1);

    // Non-square geometry: 7 columns x 6 rows gives two valid rows.
    runFrame(1'b1, 8'h00, 6, 7, 1'b0);
    checkVal("7x6 valid count", nValid, 14);
    checkVal("7x6 done count", nDone, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
